// File: rtl/xy_noc_pkg.sv
// Shared NoC definitions: packet field widths, port direction indices,
// requester count and the arbiter FSM encoding.
package xy_noc_pkg;

   localparam int PACKET_ADDR_X_W = 4;
   localparam int PACKET_ADDR_Y_W = 4;
   localparam int PACKET_DATA_W   = 8;
   localparam int PACKET_W        = PACKET_ADDR_X_W + PACKET_ADDR_Y_W + PACKET_DATA_W;

   // Requester / direction indices
   localparam int LEFT  = 0;
   localparam int TOP   = 1;
   localparam int RIGHT = 2;
   localparam int BOT   = 3;
   localparam int RES   = 4;
   localparam int REQ_N = 5;

   // Requester index and pointer width
   localparam int IDX_W = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } arb_state_t;

   // Advance a requester index by one, wrapping explicitly at n rather than
   // at the next power of two.
   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx,
                                                 input int               n);
      return (int'(idx) + 1 >= n) ? '0 : idx + 1'b1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: selects the first set request scanning from
// ptr upward with wrap at N. Purely combinational.
module rr_pick
   import xy_noc_pkg::*;
#(
   parameter int N = xy_noc_pkg::REQ_N
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             any
);

   // Scan N positions starting at ptr and latch onto the first active request.
   always_comb begin
      logic [IDX_W-1:0] sel;
      // NOTE: every output gets a default before the loop so no path leaves
      // it unassigned, which would otherwise infer a latch.
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      sel       = '0;
      for (int i = 0; i < N; i++) begin
         sel = IDX_W'((int'(ptr) + i) % N);
         if (!any && req[sel]) begin
            any        = 1'b1;
            grant_idx  = sel;
            grant[sel] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/xy_rr_arbiter.sv
// Round-robin input arbiter in front of the XY routing stage. Holds one
// packet at a time; a new winner is captured whenever the stage is empty
// or the held packet is being accepted, giving 1 packet/cycle throughput.
// Optional per-requester grant counters are built when XY_ARB_STATS_EN
// is defined.
module xy_rr_arbiter
   import xy_noc_pkg::*;
#(
   parameter int REQ_N    = xy_noc_pkg::REQ_N,
   parameter int PACKET_W = xy_noc_pkg::PACKET_W
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [REQ_N-1:0]             req_vld_i,
   input  logic [PACKET_W*REQ_N-1:0]    req_pckt_i,
   output logic [REQ_N-1:0]             req_rd_o,
   output logic                         out_vld_o,
   output logic [PACKET_W-1:0]          out_pckt_o,
   input  logic                         out_rd_i,
   output logic [2:0]                   grant_idx_o
`ifdef XY_ARB_STATS_EN
   ,
   input  logic                         stat_clr_i,
   output logic [8*REQ_N-1:0]           grant_cnt_o
`endif
);

   arb_state_t       state;
   arb_state_t       state_next;
   logic [IDX_W-1:0] ptr;
   logic [REQ_N-1:0] pick_oh;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;
   logic             capture;
   logic             take;

   rr_pick #(
      .N (REQ_N)
   ) u_pick (
      .req       (req_vld_i),
      .ptr       (ptr),
      .grant     (pick_oh),
      .grant_idx (pick_idx),
      .any       (pick_any)
   );

   // The holding register may load when empty, or when its packet leaves.
   // Reset suppresses the pop strobe so no requester loses a packet.
   assign capture   = (state == ST_IDLE) || out_rd_i;
   assign take      = capture && pick_any && !rst_i;
   assign req_rd_o  = take ? pick_oh : '0;
   assign out_vld_o = (state == ST_HOLD);

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= ST_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every
         // register samples pre-edge values regardless of block order.
         state <= state_next;
      end
   end

   // Next state: on a capture, HOLD if anything was picked, else IDLE.
   always_comb begin
      state_next = state;
      if (capture) begin
         state_next = pick_any ? ST_HOLD : ST_IDLE;
      end
   end

   // Held packet, grant index and round-robin pointer.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr         <= '0;
         out_pckt_o  <= '0;
         grant_idx_o <= '0;
      end else if (capture) begin
         if (pick_any) begin
            out_pckt_o  <= req_pckt_i[pick_idx*PACKET_W +: PACKET_W];
            grant_idx_o <= pick_idx;
            ptr         <= wrap_inc(pick_idx, REQ_N);
         end else begin
            grant_idx_o <= '0;
         end
      end
   end

`ifdef XY_ARB_STATS_EN
   // Per-requester saturating grant counters; a clear beats an increment.
   for (genvar k = 0; k < REQ_N; k++) begin : g_cnt
      logic [7:0] cnt;

      // Count captures of requester k, saturating at 255.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            cnt <= '0;
         end else if (stat_clr_i) begin
            cnt <= '0;
         end else if (take && pick_oh[k] && (cnt != 8'hFF)) begin
            cnt <= cnt + 8'd1;
         end
      end

      assign grant_cnt_o[8*k +: 8] = cnt;
   end
`endif

endmodule

// File: tb/tb_xy_rr_arbiter.sv
// Directed self-checking bench for xy_rr_arbiter. Build with
// XY_ARB_STATS_EN defined to also exercise the grant counters.
module tb_xy_rr_arbiter;

   logic        clk;
   logic        rst;
   logic [4:0]  req_vld;
   logic [79:0] req_pckt;
   logic [4:0]  req_rd;
   logic        out_vld;
   logic [15:0] out_pckt;
   logic        out_rd;
   logic [2:0]  grant_idx;
`ifdef XY_ARB_STATS_EN
   logic        stat_clr;
   logic [39:0] grant_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   logic [15:0] p [5];
   int          gexp [6];
   logic [4:0]  rexp [6];
   logic [4:0]  hold_vec [4];

   assign req_pckt = {p[4], p[3], p[2], p[1], p[0]};

   xy_rr_arbiter dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_vld_i   (req_vld),
      .req_pckt_i  (req_pckt),
      .req_rd_o    (req_rd),
      .out_vld_o   (out_vld),
      .out_pckt_o  (out_pckt),
      .out_rd_i    (out_rd),
      .grant_idx_o (grant_idx)
`ifdef XY_ARB_STATS_EN
      ,
      .stat_clr_i  (stat_clr),
      .grant_cnt_o (grant_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      p[0] = 16'h0A00;
      p[1] = 16'h1B11;
      p[2] = 16'h23A5;
      p[3] = 16'h3C33;
      p[4] = 16'h4D44;
      gexp = '{0, 1, 2, 3, 4, 0};
      rexp = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001, 5'b00010};
      hold_vec = '{5'b11111, 5'b00101, 5'b11010, 5'b01000};

      // Reset with every request active: no pop strobe may leak out.
      rst     = 1'b1;
      req_vld = 5'b11111;
      out_rd  = 1'b1;
`ifdef XY_ARB_STATS_EN
      stat_clr = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #2;
      check("rst_out_vld", 32'(out_vld), 32'd0);
      check("rst_out_pckt", 32'(out_pckt), 32'h0);
      check("rst_grant_idx", 32'(grant_idx), 32'd0);
      check("rst_req_rd", 32'(req_rd), 32'h0);

      // Single request from RIGHT: popped same cycle, held next cycle.
      tick();
      rst     = 1'b0;
      req_vld = 5'b00100;
      out_rd  = 1'b0;
      #1;
      check("first_req_rd", 32'(req_rd), 32'b00100);
      check("first_vld_pre", 32'(out_vld), 32'd0);

      tick();
      req_vld = 5'b00000;
      #1;
      check("first_out_vld", 32'(out_vld), 32'd1);
      check("first_out_pckt", 32'(out_pckt), 32'h23A5);
      check("first_grant_idx", 32'(grant_idx), 32'd2);
      check("first_hold_rd", 32'(req_rd), 32'h0);

      // ptr must now be 3: all requesting, accept held packet.
      tick();
      req_vld = 5'b11111;
      out_rd  = 1'b1;
      #1;
      check("ptr3_held_pckt", 32'(out_pckt), 32'h23A5);
      check("ptr3_req_rd", 32'(req_rd), 32'b01000);

      tick();
      check("g3_grant_idx", 32'(grant_idx), 32'd3);
      check("g3_out_pckt", 32'(out_pckt), 32'h3C33);
      check("g3_req_rd", 32'(req_rd), 32'b10000);

      tick();
      check("g4_grant_idx", 32'(grant_idx), 32'd4);
      check("g4_out_pckt", 32'(out_pckt), 32'h4D44);
      check("g4_req_rd_wrap", 32'(req_rd), 32'b00001);

      // Full-rate round robin from ptr=0: grants 0,1,2,3,4,0.
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("rr%0d_out_vld", i), 32'(out_vld), 32'd1);
         check($sformatf("rr%0d_grant_idx", i), 32'(grant_idx), 32'(gexp[i]));
         check($sformatf("rr%0d_out_pckt", i), 32'(out_pckt), 32'(p[gexp[i]]));
         check($sformatf("rr%0d_req_rd", i), 32'(req_rd), 32'(rexp[i]));
      end

      // Stall: hold grant 1 while requests toggle.
      tick();
      out_rd = 1'b0;
      #1;
      check("stall_grant_idx", 32'(grant_idx), 32'd1);
      check("stall_out_pckt", 32'(out_pckt), 32'h1B11);
      check("stall_req_rd", 32'(req_rd), 32'h0);
      for (int i = 0; i < 4; i++) begin
         tick();
         req_vld = hold_vec[i];
         #1;
         check($sformatf("hold%0d_out_vld", i), 32'(out_vld), 32'd1);
         check($sformatf("hold%0d_grant_idx", i), 32'(grant_idx), 32'd1);
         check($sformatf("hold%0d_out_pckt", i), 32'(out_pckt), 32'h1B11);
         check($sformatf("hold%0d_req_rd", i), 32'(req_rd), 32'h0);
      end

      // Release stall: ptr must still be 2.
      tick();
      req_vld = 5'b11111;
      out_rd  = 1'b1;
      #1;
      check("unstall_req_rd", 32'(req_rd), 32'b00100);

      tick();
      req_vld = 5'b01000;
      #1;
      check("g2_grant_idx", 32'(grant_idx), 32'd2);
      check("g2_out_pckt", 32'(out_pckt), 32'h23A5);
      check("g2_req_rd", 32'(req_rd), 32'b01000);

      // ptr=4 with LEFT and TOP requesting: wrap to 0, then 1.
      tick();
      req_vld = 5'b00011;
      #1;
      check("wrap_grant3", 32'(grant_idx), 32'd3);
      check("wrap_req_rd0", 32'(req_rd), 32'b00001);

      tick();
      check("wrap_grant0", 32'(grant_idx), 32'd0);
      check("wrap_pckt0", 32'(out_pckt), 32'h0A00);
      check("wrap_req_rd1", 32'(req_rd), 32'b00010);

      tick();
      req_vld = 5'b00000;
      #1;
      check("wrap_grant1", 32'(grant_idx), 32'd1);
      check("empty_req_rd", 32'(req_rd), 32'h0);

      // Empty capture returns to IDLE; out_rd while idle changes nothing.
      tick();
      check("idle_out_vld", 32'(out_vld), 32'd0);
      check("idle_grant_idx", 32'(grant_idx), 32'd0);
      check("idle_req_rd", 32'(req_rd), 32'h0);

      tick();
      check("idle_rd_ignored", 32'(out_vld), 32'd0);

      // ptr unchanged by empty captures: still 2.
      tick();
      req_vld = 5'b11111;
      out_rd  = 1'b0;
      #1;
      check("idle_ptr_req_rd", 32'(req_rd), 32'b00100);

      tick();
      check("pre_rst_out_vld", 32'(out_vld), 32'd1);
      check("pre_rst_grant", 32'(grant_idx), 32'd2);

      // Reset pulse in HOLD: drop the packet at once, restart from ptr=0.
      rst = 1'b1;
      #1;
      check("hold_rst_out_vld", 32'(out_vld), 32'd0);
      check("hold_rst_grant", 32'(grant_idx), 32'd0);
      check("hold_rst_pckt", 32'(out_pckt), 32'h0);
      check("hold_rst_req_rd", 32'(req_rd), 32'h0);

      tick();
      rst = 1'b0;
      #1;
      check("post_rst_req_rd", 32'(req_rd), 32'b00001);
      check("post_rst_vld", 32'(out_vld), 32'd0);

      tick();
      check("post_rst_grant", 32'(grant_idx), 32'd0);
      check("post_rst_pckt", 32'(out_pckt), 32'h0A00);
      check("post_rst_out_vld", 32'(out_vld), 32'd1);

`ifdef XY_ARB_STATS_EN
      // Counters: clear, saturate RESOURCE at 255, then clear beats a grant.
      req_vld  = 5'b10000;
      out_rd   = 1'b1;
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      #1;
      check("cnt_cleared", 32'(grant_cnt[39:32]), 32'd0);

      repeat (300) @(posedge clk);
      #1;
      check("cnt_saturated", 32'(grant_cnt[39:32]), 32'd255);

      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      #1;
      check("cnt_clr_wins", 32'(grant_cnt[39:32]), 32'd0);

      tick();
      check("cnt_after_clr", 32'(grant_cnt[39:32]), 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/xy_rr_arbiter.md
XY_RR_ARBITER -- requirements
Module: xy_rr_arbiter

Interface
REQ-001 Parameter REQ_N, default 5, number of requesters: LEFT=0, TOP=1, RIGHT=2, BOT=3, RESOURCE=4.
REQ-002 Parameter PACKET_W, default 16, packet width: X addr 4 | Y addr 4 | data 8, MSB first.
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 req_vld_i  input  REQ_N  per-requester packet valid.
REQ-006 req_pckt_i  input  PACKET_W*REQ_N  packets, requester k at bits [(k+1)*PACKET_W-1 : k*PACKET_W].
REQ-007 req_rd_o  output  REQ_N  one-hot pop strobe; requester k drops or advances its packet on the cycle after req_rd_o[k]=1.
REQ-008 out_vld_o  output  1  held packet valid toward the XY routing stage.
REQ-009 out_pckt_o  output  PACKET_W  held packet.
REQ-010 out_rd_i  input  1  routing stage accepts the held packet.
REQ-011 grant_idx_o  output  3  index of the requester whose packet is held; 0 when out_vld_o=0.

Function
REQ-012 FSM has two states: IDLE (out_vld_o=0) and HOLD (out_vld_o=1).
REQ-013 The capture condition is (state==IDLE) or (state==HOLD and out_rd_i=1).
REQ-014 In a capture cycle with any req_vld_i set, winner = first set bit scanning ptr, ptr+1, ..., REQ_N-1, 0, ..., ptr-1.
REQ-015 In that cycle req_rd_o = one-hot(winner), combinationally, including the path from out_rd_i.
REQ-016 On the next edge the packet is registered into out_pckt_o, grant_idx_o <= winner, state <= HOLD, and ptr <= (winner+1) mod REQ_N.
REQ-017 Capture with no req_vld_i set: state <= IDLE, out_vld_o <= 0, ptr unchanged, req_rd_o all zero.
REQ-018 In HOLD with out_rd_i=0: out_pckt_o and grant_idx_o are stable, req_rd_o all zero, and ptr is unchanged.
REQ-019 Latency from req_vld_i to out_vld_o is 1 cycle from IDLE; back-to-back acceptance sustains 1 packet per cycle.
REQ-020 out_rd_i while in IDLE is ignored.
REQ-021 ptr wraps from REQ_N-1 to 0; ptr arithmetic is 3-bit with explicit mod REQ_N, not a power-of-2 wrap.
REQ-022 A requester that holds req_vld_i continuously is granted within REQ_N captures (no starvation).
REQ-023 req_rd_o never asserts for a requester whose req_vld_i=0.

Reset
REQ-024 While rst_i=1: state=IDLE, ptr=0, out_vld_o=0, out_pckt_o=0, grant_idx_o=0, req_rd_o=0.
REQ-025 Reset asserted in HOLD discards the held packet with no pop strobe reissued; after release, arbitration restarts from ptr=0.

Configuration
REQ-026 Macro XY_ARB_STATS_EN is defined: adds input stat_clr_i (1) and output grant_cnt_o (8*REQ_N), an 8-bit per-requester counter incremented on each capture of that requester.
REQ-027 The counters saturate at 255.
REQ-028 stat_clr_i clears all counters synchronously and wins over a same-cycle increment.
REQ-029 The counters reset to 0.
REQ-030 Macro XY_ARB_STATS_EN is undefined: the counter ports and counter logic are absent; all other behaviour is identical.

Structure
REQ-031 Shared package xy_noc_pkg holds: PACKET_ADDR_X_W=4, PACKET_ADDR_Y_W=4, PACKET_DATA_W=8, PACKET_W, direction indices LEFT/TOP/RIGHT/BOT/RES, REQ_N, and the FSM state encoding.
REQ-032 Sub-module rr_pick: combinational rotating priority encoder (inputs req vector and ptr; outputs one-hot grant, grant index and any-valid flag), instantiated once.

Verification
REQ-033 Reset, then req_vld_i=5'b00100 with packet 16'h23A5 -> req_rd_o=5'b00100 the same cycle, next cycle out_vld_o=1, out_pckt_o=16'h23A5, grant_idx_o=2, ptr=3.
REQ-034 All five valid, out_rd_i=1 constantly, from ptr=0 -> grant order 0,1,2,3,4,0 on consecutive cycles with out_vld_o continuously 1.
REQ-035 HOLD with out_rd_i=0 for 4 cycles while other requests toggle -> out_pckt_o stable, req_rd_o=0, and ptr unchanged throughout.
REQ-036 ptr=4, req_vld_i=5'b00011 -> winner 0, then ptr=1 and winner 1 on the next capture (wrap).
REQ-037 rst_i pulsed for 1 cycle in HOLD -> out_vld_o=0 immediately; first post-reset grant follows ptr=0.
REQ-038 With XY_ARB_STATS_EN: 300 grants to RESOURCE -> grant_cnt_o[39:32]=255; stat_clr_i together with a grant -> 0.
